// File: rtl/muldiv.sv
// muldiv -- iterative multiply/divide unit for the MIPS HI/LO operations.
//
// Ops (i_op): 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored.
// Multiply is radix-2 shift-add and divide is restoring shift-subtract, both
// on operand magnitudes over WIDTH cycles. Sign correction is applied in FIX.
// HI/LO are owned here and only change on MTHI/MTLO or on a completing op.
//
// Optional feature: define CPU_MULDIV_DIV_EN to build the divider. Without it,
// DIV/DIVU complete immediately (done pulse next cycle, HI/LO unchanged).
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_start        request strobe (ignored while o_busy)
//   i_op[2:0]      operation code
//   i_a, i_b       operands (i_a also carries MTHI/MTLO data)
//   i_flush        abort: back to IDLE, no done, HI/LO untouched
//   o_busy         operation in flight
//   o_done         one-cycle pulse, HI/LO just updated
//   o_hi, o_lo     architectural HI/LO registers
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state, w_state_n;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // {hi half, lo half} working register
  logic [WIDTH-1:0]   r_b;       // multiplicand or divisor magnitude
  logic               r_neg_res; // operand signs differ
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic w_accept, w_mt_hi, w_mt_lo, w_fix, w_nodiv_done;

  // Operand magnitudes; only the signed ops look at the sign bits.
  logic             w_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_sgn   = (i_op == 3'd0) || (i_op == 3'd2);
  assign w_a_neg = w_sgn & i_a[WIDTH-1];
  assign w_b_neg = w_sgn & i_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -i_a : i_a;
  assign w_mag_b = w_b_neg ? -i_b : i_b;

  // Multiply step: multiplier sits in the low half and shifts out LSB first.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_step, w_prod;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_step = {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_neg_res ? -r_acc : r_acc;

  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

`ifdef CPU_MULDIV_DIV_EN
  logic r_is_div, r_neg_a;

  // Divide step: remainder in the high half, dividend/quotient in the low half.
  // When shl >= divisor the difference is below the divisor, so W bits suffice.
  logic [WIDTH:0]     w_shl;
  logic [WIDTH-1:0]   w_diff, w_q, w_r;
  logic               w_ge, w_div0;
  logic [2*WIDTH-1:0] w_div_step;
  assign w_shl      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = w_shl >= {1'b0, r_b};
  assign w_diff     = w_shl[WIDTH-1:0] - r_b;
  assign w_div_step = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {w_shl[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  assign w_step     = r_is_div ? w_div_step : w_mul_step;

  // With a zero divisor the datapath yields q = all ones and r = |a|; giving r
  // the dividend's sign restores a exactly, so only the quotient fix is skipped.
  assign w_q      = r_acc[WIDTH-1:0];
  assign w_r      = r_acc[2*WIDTH-1:WIDTH];
  assign w_div0   = (r_b == '0);
  assign w_fix_lo = r_is_div ? ((r_neg_res & ~w_div0) ? -w_q : w_q) : w_prod[WIDTH-1:0];
  assign w_fix_hi = r_is_div ? (r_neg_a ? -w_r : w_r) : w_prod[2*WIDTH-1:WIDTH];
`else
  assign w_step   = w_mul_step;
  assign w_fix_lo = w_prod[WIDTH-1:0];
  assign w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    w_state_n    = r_state;
    w_accept     = 1'b0;
    w_mt_hi      = 1'b0;
    w_mt_lo      = 1'b0;
    w_fix        = 1'b0;
    w_nodiv_done = 1'b0;
    if (i_flush) begin
      w_state_n = IDLE;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          case (i_op)
            3'd0, 3'd1: begin w_accept = 1'b1; w_state_n = RUN; end
`ifdef CPU_MULDIV_DIV_EN
            3'd2, 3'd3: begin w_accept = 1'b1; w_state_n = RUN; end
`else
            3'd2, 3'd3: w_nodiv_done = 1'b1;
`endif
            3'd4: w_mt_hi = 1'b1;
            3'd5: w_mt_lo = 1'b1;
            default: ;
          endcase
        end
        RUN: if (r_cnt == CW'(1)) w_state_n = FIX;
        FIX: begin w_fix = 1'b1; w_state_n = IDLE; end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_neg_res <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
`ifdef CPU_MULDIV_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_a   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_done  <= w_fix | w_nodiv_done;
      if (w_accept) begin
        r_cnt     <= CW'(WIDTH);
        r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef CPU_MULDIV_DIV_EN
        r_is_div  <= i_op[1];
        r_neg_a   <= w_a_neg;
        r_acc     <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_a : w_mag_b)};
        r_b       <= i_op[1] ? w_mag_b : w_mag_a;
`else
        r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
        r_b       <= w_mag_a;
`endif
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= w_step;
      end
      if (w_mt_hi) r_hi <= i_a;
      if (w_mt_lo) r_lo <= i_a;
      if (w_fix) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
endmodule

// File: tb/tb_muldiv.sv
// Randomized scoreboard bench for muldiv (WIDTH=32). Expected HI/LO come from
// plain 64-bit arithmetic; a monitor pops and compares on every done pulse.
module tb_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .i_flush(i_flush), .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: returns {hi, lo} after the op, given the current HI/LO.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return 64'(p); end
      3'd1: begin u = {32'b0, a} * {32'b0, b}; return u; end
`ifdef CPU_MULDIV_DIV_EN
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        u = 64'(q); p = r;
        return {p[31:0], u[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
`endif
      default: return {m_hi, m_lo};
    endcase
  endfunction

  function automatic int busy_len(input logic [2:0] op);
`ifdef CPU_MULDIV_DIV_EN
    return 33;
`else
    return (op <= 3'd1) ? 33 : 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done hi=%h lo=%h required=no_done", o_hi, o_lo);
      end else begin
        chk("done_hilo", {o_hi, o_lo}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a request at the next edge; returns positioned 1 time unit after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_result);
    logic [63:0] r;
    int n = 0;
    while (o_busy && n < 100) begin step(); n++; end
    if (o_busy) chk("idle_wait_timeout", 64'(o_busy), 64'd0);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    if (expect_result) begin
      if (op <= 3'd3) begin
        r = model(op, a, b);
        m_hi = r[63:32]; m_lo = r[31:0];
        exp_q.push_back(r);
      end else if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
    step();
    i_start = 1'b0;
  endtask

  // Count remaining busy cycles, then expect the done pulse.
  task automatic finish(input int exp_busy);
    int cnt = 0;
    while (o_busy && cnt < 100) begin cnt++; step(); end
    chk("busy_cycles", 64'(cnt), 64'(exp_busy));
    chk("done_pulse", 64'(o_done), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b1);
    if (op <= 3'd3) finish(busy_len(op));
    else begin
      chk("mt_hilo", {o_hi, o_lo}, {m_hi, m_lo});
      chk("mt_no_busy_done", {62'd0, o_busy, o_done}, 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    logic [31:0] a, b;
    rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    repeat (3) step();
    chk("reset_state", {o_busy, o_done, o_hi, o_lo}, 66'd0);
    rst = 1'b0;
    step();

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd3, 32'h0000_1234, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h0000_0064, 32'hFFFF_FFF9);
    run_op(3'd4, 32'hA5A5_A5A5, 32'd0);
    run_op(3'd5, 32'h5A5A_0001, 32'd0);

    // MULTU 3x4 with a DIVU presented mid-run; the second start must vanish.
    issue(3'd1, 32'd3, 32'd4, 1'b1);
    repeat (9) step();
    i_start = 1'b1; i_op = 3'd3; i_a = 32'd100; i_b = 32'd7;
    step();
    i_start = 1'b0;
    finish(23);
    repeat (40) step();
    chk("ignored_start_hilo", {o_hi, o_lo}, {m_hi, m_lo});

    // Flush mid-run: no done, HI/LO keep their values.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (14) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("flush_busy_done", {62'd0, o_busy, o_done}, 64'd0);
    repeat (40) step();
    chk("flush_hilo", {o_hi, o_lo}, {m_hi, m_lo});

    // Flush and MTHI on the same edge: request dropped.
    i_start = 1'b1; i_op = 3'd4; i_a = 32'hDEAD_BEEF; i_flush = 1'b1;
    step();
    i_start = 1'b0; i_flush = 1'b0;
    chk("flush_start_hilo", {o_hi, o_lo}, {m_hi, m_lo});

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 5));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(op, a, b);
    end

    // Reset in the middle of a run clears everything at once.
    issue(3'd0, 32'h7777_0001, 32'h0000_0003, 1'b0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("async_reset", {o_busy, o_done, o_hi, o_lo}, 66'd0);
    m_hi = '0; m_lo = '0;
    step();
    rst = 1'b0;
    repeat (3) step();
    run_op(3'd1, 32'd6, 32'd7);
    repeat (3) step();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit completing the CPU execute stage for the MIPS HI/LO operations (MULT, MULTU, DIV, DIVU, MTHI, MTLO) that the single-cycle ALU does not cover. The execute stage drives operands and an operation code with a start strobe. The unit runs a radix-2 shift-add or shift-subtract sequence over WIDTH cycles and owns the architectural HI/LO registers. Writeback reads HI/LO directly for MFHI/MFLO.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥4
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe, sampled each edge
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data
- b  in  WIDTH  multiplier / divisor
- flush  in  1  abort in-flight operation (exception/pipeline flush)
- busy  out  1  operation in flight; new start ignored
- done  out  1  one-cycle pulse, HI/LO just updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1, op 0–3: latch operand magnitudes (|a|, |b| for signed ops; raw values for unsigned ops), latch result signs, clear accumulator, load counter=WIDTH, go RUN, busy=1.
- IDLE, start=1, op 4/5: HI (op 4) or LO (op 5) ← a at that edge; no busy, no done.
- IDLE, start=1, op 6/7: ignored.
- RUN: one iteration per cycle; counter decrements; go FIX when counter reaches 0.
  - Multiply: 2·WIDTH-bit shift-add.
  - Divide: restoring shift-subtract; quotient to LO, remainder to HI.
- FIX: apply sign correction, write HI/LO, pulse done, go IDLE, busy=0.
  - MULT: negate the 2·WIDTH product if operand signs differ.
  - DIV: negate quotient if signs differ; remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): LO = all ones, HI = a; sign correction skipped.
- DIV of most-negative value by −1: LO = most-negative value, HI = 0. This result falls out of the magnitude datapath; no special case.
- start while busy: ignored, no queuing. The issuer must wait for busy=0.
- flush=1 in any state: return to IDLE next edge, busy=0, no done, HI/LO unchanged.
  - flush and start on the same edge in IDLE: flush wins and the request is dropped.
  - flush during FIX: HI/LO not written.
- Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.

## Timing
- Start accepted at edge E0 for ops 0–3:
  - busy high from E0 until E(WIDTH+1).
  - HI/LO updated and done high in the cycle after edge E(WIDTH+1): WIDTH+1 edges of latency, 33 for WIDTH=32.
- busy falls on the same edge done rises. A new start may be presented in the done cycle and is accepted.
- MTHI/MTLO: HI/LO visible one edge after the start edge.
- hi/lo outputs hold during RUN; there are no partial results.

## Configuration
- CPU_MULDIV_DIV_EN defined: divider datapath and DIV/DIVU behave as above.
- CPU_MULDIV_DIV_EN undefined: divide logic is removed. DIV/DIVU start gives busy=0, a done pulse on the next cycle, and HI/LO unchanged, so the pipeline never stalls. Multiply and MTHI/MTLO are unaffected.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done after 33 edges; HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV by zero and overflow:
  - DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI a=0xA5A5A5A5 -> hi=0xA5A5A5A5 next edge, no done. Then MULTU 3×4, with a second start (DIVU) issued at cycle 10 -> second start ignored; LO=12, HI=0.
- Abort and reset:
  - MULTU started, flush at cycle 15 -> busy low next edge, no done, HI/LO keep prior values.
  - rst asserted mid-RUN -> busy, done, hi, lo all 0 immediately.
